led_chaser_tick: RTL and testbench

Consumes the slow square wave from the board clock divider (nominally 1 Hz from 24 MHz) and drives a one-hot LED chaser. Synchronises the slow clock into the clk_in domain and extracts a single-cycle rising-edge tick. Each tick advances a mode-selectable pattern state machine: shift left, shift right, bounce or hold. Sits directly downstream of the divider on the FPGA test top level.

---
 rtl/gcore_led_pkg.sv | 28 ++
 rtl/tick_sync.sv | 40 ++++
 rtl/led_chaser_tick.sv | 119 +++++++++++
 tb/tb_led_chaser_tick.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcore_led_pkg.sv
// Shared definitions for the LED chaser family: pattern state encodings
// and mode select codes. Optional feature macro: BOUNCE_MODE_EN.
package gcore_led_pkg;

  // 3-bit state encodings
  localparam logic [2:0] ST_LEFT      = 3'd0;
  localparam logic [2:0] ST_RIGHT     = 3'd1;
  localparam logic [2:0] ST_BOUNCE_UP = 3'd2;
  localparam logic [2:0] ST_BOUNCE_DN = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  typedef enum logic [2:0] {
    S_LEFT      = ST_LEFT,
    S_RIGHT     = ST_RIGHT,
`ifdef BOUNCE_MODE_EN
    S_BOUNCE_UP = ST_BOUNCE_UP,
    S_BOUNCE_DN = ST_BOUNCE_DN,
`endif
    S_HOLD      = ST_HOLD
  } state_e;

  // Pattern select codes on the mode input
  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/tick_sync.sv
// Three-flop synchroniser for an asynchronous slow clock plus a registered
// single-cycle rising-edge tick. After reset the tick is only armed once the
// synchronised input has been observed low, so releasing reset while the
// slow clock is already high does not create a spurious tick.
module tick_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic slow_clk,
  output logic tick
);

  logic s1_q, s2_q, s3_q;
  logic v1_q, v2_q;     // marks s2_q as holding real sampled data
  logic armed_q;
  logic tick_q;

  // Synchroniser chain, fill tracking, arming and tick register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= slow_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      armed_q <= armed_q | (v2_q & ~s2_q);
      tick_q  <= s2_q & ~s3_q & armed_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_chaser_tick.sv
// One-hot LED chaser advanced by synchronised ticks of a slow clock.
// Modes: left, right, bounce, hold. Optional feature macro: BOUNCE_MODE_EN
// (when undefined, the bounce mode code behaves as hold).
module led_chaser_tick
  import gcore_led_pkg::*;
#(
  parameter int LEDS  = 8,
  parameter int POS_W = 5
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            slow_clk,
  input  logic [1:0]      mode,
  input  logic            run,
  output logic [LEDS-1:0] led,
  output logic            tick,
  output logic            wrap
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LEDS - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [LEDS-1:0]  LED_ONE  = {{(LEDS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LEDS-1:0]  led_q, led_d;
  logic             wrap_q, wrap_d;
  logic             tick_s;

  tick_sync u_tick_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .slow_clk (slow_clk),
    .tick     (tick_s)
  );

  // Next pattern state, position and wrap pulse on a qualifying tick
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    if (tick_s && run) begin
      case (mode)
        MODE_LEFT: begin
          state_d = S_LEFT;
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end
        MODE_RIGHT: begin
          state_d = S_RIGHT;
          if (pos_q == '0) begin
            pos_d  = POS_LAST;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - POS_ONE;
          end
        end
`ifdef BOUNCE_MODE_EN
        MODE_BOUNCE: begin
          if (state_q == S_BOUNCE_DN) begin
            if (pos_q == '0) begin
              state_d = S_BOUNCE_UP;
              pos_d   = POS_ONE;
              wrap_d  = 1'b1;
            end else begin
              state_d = S_BOUNCE_DN;
              pos_d   = pos_q - POS_ONE;
            end
          end else begin
            // Both S_BOUNCE_UP and entry from a non-bounce state climb
            if (pos_q == POS_LAST) begin
              state_d = S_BOUNCE_DN;
              pos_d   = pos_q - POS_ONE;
              wrap_d  = 1'b1;
            end else begin
              state_d = S_BOUNCE_UP;
              pos_d   = pos_q + POS_ONE;
            end
          end
        end
`endif
        MODE_HOLD: begin
          state_d = S_HOLD;
        end
        default: begin
          // Bounce code with the bounce feature compiled out
          state_d = S_HOLD;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    led_d = LED_ONE << pos_d;
  end

  // Pattern state, position, LED and wrap registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEFT;
      pos_q   <= '0;
      led_q   <= LED_ONE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
    end
  end

  assign led  = led_q;
  assign wrap = wrap_q;
  assign tick = tick_s;

endmodule

// File: tb/tb_led_chaser_tick.sv
// Self-checking bench for led_chaser_tick. Expected {wrap, led} values are
// pushed to a scoreboard queue when each slow_clk rise is driven and popped
// when the DUT updates its LEDs after the resulting tick.
module tb_led_chaser_tick;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       slow_clk = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       run = 1'b1;
  logic [7:0] led;
  logic       tick;
  logic       wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0] sb[$];
  int m_pos = 0;
  int m_st  = 0;   // 0 left, 1 right, 2 up, 3 down, 4 hold

  led_chaser_tick #(.LEDS(8), .POS_W(5)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .slow_clk (slow_clk),
    .mode     (mode),
    .run      (run),
    .led      (led),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] onehot(input int p);
    logic [7:0] v;
    v = 8'd0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reference behaviour for one slow_clk rise; pushes the expected result
  task automatic model_step();
    logic w;
    w = 1'b0;
    if (run) begin
      case (mode)
        2'b00: begin m_st = 0; if (m_pos == 7) begin m_pos = 0; w = 1'b1; end else m_pos++; end
        2'b01: begin m_st = 1; if (m_pos == 0) begin m_pos = 7; w = 1'b1; end else m_pos--; end
        2'b10: begin
`ifdef BOUNCE_MODE_EN
          if (m_st == 3) begin
            if (m_pos == 0) begin m_pos = 1; m_st = 2; w = 1'b1; end else m_pos--;
          end else begin
            if (m_pos == 7) begin m_pos = 6; m_st = 3; w = 1'b1; end
            else begin m_pos++; m_st = 2; end
          end
`else
          m_st = 4;
`endif
        end
        default: m_st = 4;
      endcase
    end
    sb.push_back({w, onehot(m_pos)});
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b0;
    slow_clk = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    m_pos = 0;
    m_st = 0;
    sb.delete();
    repeat (4) @(negedge clk_in);
  endtask

  // One slow_clk rise held high for hi cycles; checks tick latency, pulse
  // width, and the scoreboard entry against the LED/wrap update
  task automatic pulse(input int hi);
    int lat;
    bit seen;
    bit extra;
    logic [8:0] exp;
    lat = 0; seen = 1'b0; extra = 1'b0;
    @(negedge clk_in);
    slow_clk = 1'b1;
    model_step();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk_in);
      #1;
      if (tick === 1'b1 && !seen) begin
        seen = 1'b1;
        lat = e;
      end else if (tick === 1'b1) begin
        extra = 1'b1;
      end
      if (seen && e == lat + 1) begin
        exp = sb.pop_front();
        total_cnt++;
        if (led !== exp[7:0]) $display("FAIL led: got 0x%02h want 0x%02h", led, exp[7:0]);
        else pass_cnt++;
        total_cnt++;
        if (wrap !== exp[8]) $display("FAIL wrap: got %b want %b (led 0x%02h)", wrap, exp[8], exp[7:0]);
        else pass_cnt++;
      end
      if (seen && e == lat + 2) begin
        total_cnt++;
        if (wrap !== 1'b0) $display("FAIL wrap_width: got %b want 0", wrap);
        else pass_cnt++;
      end
      @(negedge clk_in);
      if (e == hi) slow_clk = 1'b0;
    end
    total_cnt++;
    if (!seen) begin
      $display("FAIL tick_timeout: got no tick want tick at edge 3");
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (lat != 3) begin
      $display("FAIL tick_latency: got %0d want 3", lat);
    end else pass_cnt++;
    total_cnt++;
    if (extra) $display("FAIL tick_width: got extra tick want single pulse");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    total_cnt++;
    if (led !== 8'h01 || tick !== 1'b0 || wrap !== 1'b0)
      $display("FAIL reset_state: got led 0x%02h tick %b wrap %b want 0x01 0 0", led, tick, wrap);
    else pass_cnt++;
    rst = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_first_tick();
    mode = 2'b00; run = 1'b1;
    pulse(4);
  endtask

  task automatic test_left_wrap();
    do_reset();
    mode = 2'b00; run = 1'b1;
    for (int i = 0; i < 8; i++) pulse(4);
  endtask

  task automatic test_right();
    do_reset();
    mode = 2'b01; run = 1'b1;
    pulse(4);
    pulse(4);
  endtask

  task automatic test_bounce();
    do_reset();
    mode = 2'b10; run = 1'b1;
    for (int i = 0; i < 15; i++) pulse(4);
  endtask

  task automatic test_run_freeze();
    do_reset();
    mode = 2'b00; run = 1'b1;
    pulse(4); pulse(4);
    run = 1'b0;
    for (int i = 0; i < 3; i++) pulse(4);
    run = 1'b1;
    pulse(4);
    mode = 2'b11;
    pulse(4); pulse(4);
  endtask

  task automatic test_single_cycle_high();
    do_reset();
    mode = 2'b00; run = 1'b1;
    pulse(1);
    pulse(1);
  endtask

  task automatic test_reset_mid();
    bit any_tick;
    do_reset();
    mode = 2'b00; run = 1'b1;
    for (int i = 0; i < 4; i++) pulse(4);
    @(negedge clk_in);
    slow_clk = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (led !== 8'h01 || tick !== 1'b0 || wrap !== 1'b0)
      $display("FAIL mid_reset: got led 0x%02h tick %b wrap %b want 0x01 0 0", led, tick, wrap);
    else pass_cnt++;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    any_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      if (tick === 1'b1) any_tick = 1'b1;
    end
    total_cnt++;
    if (any_tick) $display("FAIL release_high: got tick want none while slow_clk held high");
    else pass_cnt++;
    @(negedge clk_in);
    slow_clk = 1'b0;
    m_pos = 0; m_st = 0;
    sb.delete();
    repeat (4) @(negedge clk_in);
    pulse(4);
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_left_wrap();
    test_right();
    test_bounce();
    test_run_freeze();
    test_single_cycle_high();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
